// File: rtl/addsub_pkg.sv
// Shared op encoding and result-flag bundle for the pipelined adder/subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Flags travel together with the result out of the last stage.
   typedef struct packed {
      logic carry;   // carry out of MSB; for SUB, 1 means no borrow
      logic ovf;     // signed overflow
      logic zero;    // result is all zeros
   } flags_t;

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle between producers, the adder pipeline and the consumer.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready handshake in each direction.
interface pipelined_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic             out_ovf;
   logic             out_zero;

   // Producer/consumer side.
   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
   );

   // Adder side.
   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
   );
endinterface

// File: rtl/addsub_segment.sv
// One SEG-bit slice of the carry chain: sum, carry-out and carry into the slice MSB.
// Latency: combinational.
// Backpressure: none; the owning pipeline decides when results are captured.
module addsub_segment #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           c_msb
);

   logic [SEG:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
   assign s    = full[SEG-1:0];
   assign co   = full[SEG];
   // Carry into the top bit is recovered from the sum bit: s = a ^ b ^ cin.
   assign c_msb = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub; one carry segment resolved per stage, flags at the end.
// Latency: beat accepted at edge N is presented after edge N+STAGES-1; 1 beat/cycle.
// Backpressure: whole pipeline stalls when out_valid & !out_ready; in_ready = !out_valid | out_ready.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic              clk,
   input  logic              rst,
   pipelined_addsub_if.slave bus
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   // Reject geometries where the carry chain cannot be split evenly.
   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_geometry
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
   end

   // Pipeline state: operands ride along until their slice is consumed, the
   // partial result fills in one slice per stage.
   logic [STAGES-1:0] vld_q, vld_d;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  a_d   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  b_d   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  sum_d [STAGES];
   logic              cy_q  [STAGES];
   logic              cy_d  [STAGES];
   flags_t            flags_q, flags_d;

   // What each stage works on this cycle.
   logic [WIDTH-1:0]  stg_a   [STAGES];
   logic [WIDTH-1:0]  stg_b   [STAGES];
   logic [WIDTH-1:0]  stg_sum [STAGES];
   logic              stg_ci  [STAGES];

   logic [SEG-1:0]    seg_sum  [STAGES];
   logic [STAGES-1:0] seg_co;
   logic              seg_cmsb [STAGES];

   logic              advance;

   assign advance = !vld_q[LAST] || bus.out_ready;

   // Stage 0 takes fresh operands (B pre-inverted for SUB, carry-in = op);
   // later stages take the previous stage's registers.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         stg_a[k]   = '0;
         stg_b[k]   = '0;
         stg_sum[k] = '0;
         stg_ci[k]  = 1'b0;
      end
      stg_a[0]  = bus.in_a;
      stg_b[0]  = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
      stg_ci[0] = bus.in_op;
      for (int k = 1; k < STAGES; k++) begin
         stg_a[k]   = a_q[k-1];
         stg_b[k]   = b_q[k-1];
         stg_sum[k] = sum_q[k-1];
         stg_ci[k]  = cy_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      addsub_segment #(.SEG(SEG)) u_seg (
         .a     (stg_a[k][k*SEG +: SEG]),
         .b     (stg_b[k][k*SEG +: SEG]),
         .ci    (stg_ci[k]),
         .s     (seg_sum[k]),
         .co    (seg_co[k]),
         .c_msb (seg_cmsb[k])
      );
   end

   // Next state: everything holds on stall, otherwise every stage advances
   // and a bubble enters stage 0 when no beat is offered.
   always_comb begin
      vld_d   = vld_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cy_d    = cy_q;
      flags_d = flags_q;
      if (advance) begin
         vld_d[0] = bus.in_valid;
         for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
         end
         for (int k = 0; k < STAGES; k++) begin
            a_d[k]                  = stg_a[k];
            b_d[k]                  = stg_b[k];
            sum_d[k]                = stg_sum[k];
            sum_d[k][k*SEG +: SEG]  = seg_sum[k];
            cy_d[k]                 = seg_co[k];
         end
         flags_d.carry = seg_co[LAST];
         flags_d.ovf   = seg_cmsb[LAST] ^ seg_co[LAST];
         flags_d.zero  = (sum_d[LAST] == '0);
      end
   end

   // Pipeline registers; reset drops every in-flight beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q   <= '0;
         flags_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            cy_q[k]  <= 1'b0;
         end
      end else begin
         vld_q   <= vld_d;
         flags_q <= flags_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
            cy_q[k]  <= cy_d[k];
         end
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = vld_q[LAST];
   assign bus.out_sum   = sum_q[LAST];
   assign bus.out_carry = flags_q.carry;
   assign bus.out_ovf   = flags_q.ovf;
   assign bus.out_zero  = flags_q.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: main 32/4 instance with directed, backpressure, reset and random traffic,
// plus (8,1), (8,8), (64,2) instances with random traffic and a throughput check.
// Expected results come from an arithmetic reference model or constants.
module tb_pipelined_addsub;
   import addsub_pkg::*;

   typedef struct {
      logic [63:0] sum;
      logic        c;
      logic        v;
      logic        z;
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   rdy_rand = 0;
   exp_t mq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [63:0] s, input logic c, input logic v, input logic z);
      exp_t e;
      e.sum = s; e.c = c; e.v = v; e.z = z; e.lat = -1; e.acc = 0;
      return e;
   endfunction

   // Reference: plain unsigned/signed arithmetic at width w.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic op);
      exp_t e;
      logic [66:0] mask, ua, ub, r;
      logic signed [66:0] sa, sb, sr, smax, smin;
      mask = (67'd1 << w) - 67'd1;
      ua = {3'b0, a} & mask;
      ub = {3'b0, b} & mask;
      r  = op ? ua - ub : ua + ub;
      e = mk(64'(r & mask), 1'b0, 1'b0, 1'b0);
      e.c = op ? (ua >= ub) : ((r >> w) != 67'd0);
      sa = $signed(ua);
      sb = $signed(ub);
      if (ua[w-1]) sa = sa - $signed(67'd1 << w);
      if (ub[w-1]) sb = sb - $signed(67'd1 << w);
      sr   = op ? sa - sb : sa + sb;
      smax = $signed((67'd1 << (w-1)) - 67'd1);
      smin = -$signed(67'd1 << (w-1));
      e.v = (sr > smax) || (sr < smin);
      e.z = (e.sum == 64'd0);
      return e;
   endfunction

   // ---------------- main instance ----------------
   pipelined_addsub_if #(.WIDTH(32)) mif ();
   pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus(mif));

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input exp_t e);
      bit ok = 0;
      mif.in_valid = 1'b1; mif.in_a = a; mif.in_b = b; mif.in_op = op;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (mif.in_ready) begin
            e.acc = cyc + 1;
            mq.push_back(e);
            ok = 1;
         end
         @(posedge clk); #1;
      end
      mif.in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_rand(input bit use_seq, input int i);
      logic [31:0] a, b;
      logic op;
      a  = use_seq ? 32'(i + 100) : $urandom;
      b  = $urandom;
      op = 1'($urandom_range(0, 1));
      send(a, b, op, model(32, {32'b0, a}, {32'b0, b}, op));
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 3000 && mq.size() != 0; i++) @(negedge clk);
      if (mq.size() != 0) chk(name, 64'(mq.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   // Random consumer stalls when enabled.
   initial forever begin
      @(posedge clk); #1;
      if (rdy_rand) mif.out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: in_ready rule, held-output stability, latency, and result check.
   initial begin : main_mon
      exp_t e;
      logic [31:0] hs;
      logic hc, hv, hz;
      bit seen = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen = 0;
         end else begin
            chk("in_ready_rule", 64'(mif.in_ready), 64'(!(mif.out_valid && !mif.out_ready)));
            if (mif.out_valid) begin
               if (mq.size() == 0) begin
                  chk("unexpected_output", 64'(mif.out_valid), 64'd0);
               end else begin
                  e = mq[0];
                  if (!seen) begin
                     seen = 1;
                     hs = mif.out_sum; hc = mif.out_carry; hv = mif.out_ovf; hz = mif.out_zero;
                     if (e.lat >= 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                  end else begin
                     chk("held_stable", {mif.out_sum, mif.out_carry, mif.out_ovf, mif.out_zero},
                         {hs, hc, hv, hz});
                  end
                  if (mif.out_ready) begin
                     chk("sum",   {32'b0, mif.out_sum}, e.sum);
                     chk("carry", 64'(mif.out_carry), 64'(e.c));
                     chk("ovf",   64'(mif.out_ovf),   64'(e.v));
                     chk("zero",  64'(mif.out_zero),  64'(e.z));
                     void'(mq.pop_front());
                     seen = 0;
                  end
               end
            end
         end
      end
   end

   // ---------------- parameter sweep instances ----------------
   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = (g == 2) ? 64 : 8;
      localparam int S = (g == 0) ? 1 : ((g == 1) ? 8 : 2);
      logic rst_g;
      exp_t q[$];
      int   popped = 0;
      int   c0 = 0;
      bit   done = 0;

      pipelined_addsub_if #(.WIDTH(W)) sif ();
      pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst_g), .bus(sif));

      initial forever begin
         exp_t e;
         @(negedge clk);
         if (!rst_g && sif.out_valid && sif.out_ready) begin
            if (q.size() == 0) begin
               chk($sformatf("sweep%0d_unexpected", g), 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               chk($sformatf("sweep%0d_sum", g), 64'(sif.out_sum), e.sum);
               chk($sformatf("sweep%0d_flags", g), {61'b0, sif.out_carry, sif.out_ovf, sif.out_zero},
                   {61'b0, e.c, e.v, e.z});
               if (popped == 0) c0 = cyc;
               if (popped == 39) chk($sformatf("sweep%0d_throughput", g), 64'(cyc - c0), 64'd39);
               popped++;
            end
         end
      end

      initial begin
         int  n = 0;
         bit  pend = 0;
         logic [63:0] a, b;
         logic op;
         rst_g = 1'b1;
         sif.in_valid = 1'b0; sif.in_op = 1'b0; sif.in_a = '0; sif.in_b = '0; sif.out_ready = 1'b1;
         repeat (3) @(negedge clk);
         rst_g = 1'b0;
         for (int cy = 0; cy < 4000 && n < 100; cy++) begin
            @(posedge clk); #1;
            sif.out_ready = (popped < 40) ? 1'b1 : 1'($urandom_range(0, 1));
            if (!pend) begin
               if (n < 40 || $urandom_range(0, 2) != 0) begin
                  a  = {$urandom, $urandom};
                  b  = {$urandom, $urandom};
                  op = 1'($urandom_range(0, 1));
                  sif.in_a = a[W-1:0]; sif.in_b = b[W-1:0]; sif.in_op = op;
                  sif.in_valid = 1'b1;
                  pend = 1;
               end else begin
                  sif.in_valid = 1'b0;
               end
            end
            @(negedge clk);
            if (sif.in_valid && sif.in_ready) begin
               q.push_back(model(W, a, b, op));
               n++;
               pend = 0;
            end
         end
         @(posedge clk); #1;
         sif.in_valid = 1'b0;
         sif.out_ready = 1'b1;
         for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
         chk($sformatf("sweep%0d_drained", g), 64'(q.size()), 64'd0);
         done = 1;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      mif.in_valid = 1'b0; mif.in_op = OP_ADD; mif.in_a = '0; mif.in_b = '0; mif.out_ready = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 64'(mif.out_valid), 64'd0);
      chk("rst_in_ready",  64'(mif.in_ready),  64'd1);
      chk("rst_out_sum",   {32'b0, mif.out_sum}, 64'd0);
      chk("rst_flags",     {61'b0, mif.out_carry, mif.out_ovf, mif.out_zero}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Plain add with latency check.
      begin
         exp_t e;
         e = mk(64'd30, 1'b0, 1'b0, 1'b0);
         e.lat = 3;
         send(32'd10, 32'd20, OP_ADD, e);
      end
      wait_drain("drain_t1");

      // Wrap-around and subtraction, back to back.
      send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, mk(64'h0,         1'b1, 1'b0, 1'b1));
      send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, mk(64'h8000_0000, 1'b0, 1'b1, 1'b0));
      send(32'd5,         32'd7,         OP_SUB, mk(64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
      send(32'd7,         32'd5,         OP_SUB, mk(64'h2,         1'b1, 1'b0, 1'b0));
      send(32'h8000_0000, 32'h0000_0001, OP_SUB, mk(64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
      send(32'h1234_5678, 32'h1234_5678, OP_SUB, mk(64'h0,         1'b1, 1'b0, 1'b1));
      wait_drain("drain_t2");

      // Back-to-back stream under random backpressure.
      rdy_rand = 1;
      for (int i = 0; i < 8; i++) send_rand(1, i);
      wait_drain("drain_t4");
      rdy_rand = 0;
      mif.out_ready = 1'b0;

      // Reset with three beats in flight and the output stalled.
      for (int i = 0; i < 3; i++) send_rand(0, i);
      for (int i = 0; i < 20 && !mif.out_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("pre_reset_valid", 64'(mif.out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(mif.out_valid), 64'd0);
      chk("async_rst_ready", 64'(mif.in_ready),  64'd1);
      mq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mif.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post_reset_idle", 64'(mif.out_valid), 64'd0);
      end
      @(posedge clk); #1;
      send(32'd1, 32'd1, OP_ADD, mk(64'd2, 1'b0, 1'b0, 1'b0));
      wait_drain("drain_t5");

      // Random traffic with gaps and stalls.
      rdy_rand = 1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         send_rand(0, i);
      end
      wait_drain("drain_rand");
      rdy_rand = 0;

      for (int i = 0; i < 5000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++) @(negedge clk);
      if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)) chk("sweep_timeout", 64'd0, 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
